// File: rtl/apb_mst_bridge_pkg.sv
// Shared types for the APB initiator bridge: default APB request/response
// structs, slave error encodings and the bridge state encoding.
package apb_mst_bridge_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = APB_DW / 8;

  // pslverr encodings
  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } mst_state_e;

  typedef struct packed {
    logic [APB_AW-1:0] paddr;
    logic [2:0]        pprot;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_DW-1:0] pwdata;
    logic [APB_SW-1:0] pstrb;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DW-1:0] prdata;
    logic              pready;
    logic              pslverr;
  } apb_resp_t;

endpackage

// File: rtl/apb_mst_bridge.sv
// APB initiator bridge: one valid/ready request becomes one APB SETUP/ACCESS
// transfer; the result comes back on a valid/ready response channel. An
// optional timeout abandons a slave that never raises pready.
//
// Handshake rule for both channels: a beat transfers on the rising clk_i edge
// where valid and ready are both 1; the response holds all fields stable while
// rsp_valid_o=1 and rsp_ready_i=0, and no request is accepted until the
// response has been consumed.
module apb_mst_bridge
  import apb_mst_bridge_pkg::*;
#(
  parameter type         req_t         = apb_req_t,
  parameter type         resp_t        = apb_resp_t,
  parameter int          AddrWidth     = 32,
  parameter int          DataWidth     = 32,
  parameter int          TimeoutCycles = 0,
  parameter logic [31:0] TimeoutData   = 32'hBADCAB1E,
  localparam int         StrbWidth     = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [StrbWidth-1:0] req_strb_i,
  input  logic [2:0]           req_prot_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 rsp_tout_o,
  output req_t                 mst_req_o,
  input  resp_t                mst_resp_i,
  output mst_state_e           dbg_state_o
);

  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [DataWidth-1:0] ToutData = DataWidth'(TimeoutData);

  mst_state_e           r_state;
  req_t                 r_mst_req;
  logic                 r_rsp_valid;
  logic [DataWidth-1:0] r_rsp_rdata;
  logic                 r_rsp_err;
  logic                 r_rsp_tout;
  logic [CntW-1:0]      r_tcnt;

  logic w_apb_done;
  logic w_tout_hit;

  // Slave completion is only meaningful in the ACCESS phase.
  assign w_apb_done = r_mst_req.psel && r_mst_req.penable && mst_resp_i.pready;
  // Last permitted ACCESS cycle; never true when the timeout is disabled.
  assign w_tout_hit = (TimeoutCycles > 0) && (r_tcnt == CntW'(TimeoutCycles - 1));

  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_tout_o  = r_rsp_tout;
  assign mst_req_o   = r_mst_req;
  assign dbg_state_o = r_state;

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_mst_req   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tout  <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_mst_req.paddr   <= req_addr_i;
            r_mst_req.pprot   <= req_prot_i;
            r_mst_req.pwrite  <= req_write_i;
            // Reads never present write data or strobes on the bus.
            r_mst_req.pwdata  <= req_write_i ? req_wdata_i : '0;
            r_mst_req.pstrb   <= req_write_i ? req_strb_i : '0;
            r_mst_req.psel    <= 1'b1;
            r_mst_req.penable <= 1'b0;
            r_state           <= SETUP;
          end
        end
        SETUP: begin
          r_mst_req.penable <= 1'b1;
          r_tcnt            <= '0;
          r_state           <= ACCESS;
        end
        ACCESS: begin
          if (w_apb_done) begin
            r_rsp_rdata       <= r_mst_req.pwrite ? '0 : mst_resp_i.prdata;
            r_rsp_err         <= (mst_resp_i.pslverr == RESP_SLVERR);
            r_rsp_tout        <= 1'b0;
            r_rsp_valid       <= 1'b1;
            r_mst_req.psel    <= 1'b0;
            r_mst_req.penable <= 1'b0;
            r_state           <= RESP;
          end else if (w_tout_hit) begin
            // Dead slave: leave the transfer without pready.
            r_rsp_rdata       <= ToutData;
            r_rsp_err         <= 1'b1;
            r_rsp_tout        <= 1'b1;
            r_rsp_valid       <= 1'b1;
            r_mst_req.psel    <= 1'b0;
            r_mst_req.penable <= 1'b0;
            r_state           <= RESP;
          end else if (TimeoutCycles > 0) begin
            r_tcnt <= r_tcnt + CntW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // APB address/control/data hold from SETUP through the end of ACCESS.
  a_apb_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == ACCESS) |-> ($stable(r_mst_req.paddr) && $stable(r_mst_req.pwrite) &&
                             $stable(r_mst_req.pwdata) && $stable(r_mst_req.pstrb) &&
                             $stable(r_mst_req.pprot) && r_mst_req.psel));

  // A stalled response keeps every field unchanged.
  a_rsp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_rsp_valid && !rsp_ready_i) |=> (r_rsp_valid && $stable(r_rsp_rdata) &&
                                       $stable(r_rsp_err) && $stable(r_rsp_tout)));

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Bench for apb_mst_bridge: directed corner transfers plus randomized
// transfers against a transaction-level model of the bridge.
module tb_apb_mst_bridge;
  import apb_mst_bridge_pkg::*;

  localparam int          TOUT      = 4;
  localparam logic [31:0] TOUT_DATA = 32'hDEAD_0BAD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr  = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb  = '0;
  logic [2:0]  req_prot  = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_tout;
  apb_req_t    mst_req;
  apb_resp_t   mst_resp = '0;
  mst_state_e  dbg_state;

  apb_mst_bridge #(
    .TimeoutCycles(TOUT),
    .TimeoutData  (TOUT_DATA)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_write_i(req_write),
    .req_wdata_i(req_wdata),
    .req_strb_i (req_strb),
    .req_prot_i (req_prot),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .rsp_tout_o (rsp_tout),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level expectation {tout, err, rdata}: a slave needing more
  // ACCESS cycles than the timeout allows gets the timeout pattern.
  function automatic logic [33:0] model_rsp(input logic w, input int waits,
                                            input logic serr, input logic [31:0] rd);
    if (waits + 1 > TOUT) return {1'b1, 1'b1, TOUT_DATA};
    return {1'b0, serr, (w ? 32'h0 : rd)};
  endfunction

  // ---------------- APB slave model ----------------
  int          slv_waits = 0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt   = 0;

  // Completes on the (slv_waits+1)-th ACCESS cycle; drives noise otherwise.
  always @(negedge clk) begin
    if (mst_req.psel && mst_req.penable) begin
      if (acc_cnt == slv_waits) begin
        mst_resp.pready  = 1'b1;
        mst_resp.prdata  = slv_rdata;
        mst_resp.pslverr = slv_err;
      end else begin
        mst_resp.pready  = 1'b0;
        mst_resp.prdata  = $urandom;
        mst_resp.pslverr = 1'($urandom_range(0, 1));
      end
      acc_cnt++;
    end else begin
      acc_cnt          = 0;
      mst_resp.pready  = 1'b0;
      mst_resp.prdata  = $urandom;
      mst_resp.pslverr = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input int waits,
                         input logic serr, input logic [31:0] rd, input int stall);
    int acc_exp, lat, n, psel_n, pen_n;
    bit seen;
    logic [33:0] exp, got;
    acc_exp = (waits + 1 < TOUT) ? waits + 1 : TOUT;
    exp_q.push_back(model_rsp(w, waits, serr, rd));
    slv_waits = waits;
    slv_err   = serr;
    slv_rdata = rd;

    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = wd;
    req_strb  = st;
    req_prot  = pr;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", 128'(n < 20), 128'(1));
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0; psel_n = 0; pen_n = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        seen = 1;
        chk("psel_in_resp", {mst_req.psel, mst_req.penable}, 2'b00);
      end else begin
        if (mst_req.psel) begin
          psel_n++;
          chk("apb_fields",
              {mst_req.paddr, mst_req.pwrite, mst_req.pwdata, mst_req.pstrb, mst_req.pprot},
              {a, w, (w ? wd : 32'h0), (w ? st : 4'h0), pr});
        end
        if (mst_req.penable) pen_n++;
        chk("req_ready_busy", req_ready, 1'b0);
      end
    end
    chk("rsp_seen", 128'(seen), 128'(1));
    exp = exp_q.pop_front();
    if (!seen) return;
    chk("rsp_latency", 128'(lat), 128'(2 + acc_exp));
    chk("psel_cycles", 128'(psel_n), 128'(1 + acc_exp));
    chk("penable_cycles", 128'(pen_n), 128'(acc_exp));
    got = {rsp_tout, rsp_err, rsp_rdata};
    chk("rsp_data", got, exp);

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rsp_hold", {rsp_valid, rsp_tout, rsp_err, rsp_rdata}, {1'b1, exp});
      chk("req_ready_resp", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("req_ready_idle", req_ready, 1'b1);
  endtask

  task automatic reset_in_access();
    slv_waits = 1000;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_setup", {mst_req.psel, mst_req.penable}, 2'b10);
    @(negedge clk);
    chk("rst_access", {mst_req.psel, mst_req.penable}, 2'b11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_apb_drop", {mst_req.psel, mst_req.penable, rsp_valid}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", req_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {rsp_valid, mst_req.psel}, 2'b00);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_mst_req", mst_req, '0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_tout, rsp_rdata}, '0);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_state", dbg_state, IDLE);

    // read, immediate pready
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h1234_5678, 0);
    // write, two wait states
    run_txn(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 3'd2, 2, 1'b0, 32'h5555_AAAA, 0);
    // error slave
    run_txn(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 3'd1, 0, 1'b1, 32'hBADCAB1E, 0);
    // pready on the last allowed ACCESS cycle wins over the timeout
    run_txn(1'b0, 32'h0000_0080, 32'h0, 4'h0, 3'd0, TOUT - 1, 1'b0, 32'h0BAD_BEEF, 0);
    // dead slave -> timeout
    run_txn(1'b0, 32'h0000_00C0, 32'h0, 4'h0, 3'd0, 1000, 1'b0, 32'h1111_2222, 0);
    // one wait state past the limit still times out
    run_txn(1'b1, 32'h0000_00C4, 32'h7777_8888, 4'h3, 3'd0, TOUT, 1'b0, 32'h0, 0);
    // stalled response, then a second request
    run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'd5, 1, 1'b0, 32'hA5A5_5A5A, 5);
    run_txn(1'b1, 32'h0000_0104, 32'h0123_4567, 4'h5, 3'd7, 0, 1'b1, 32'h0, 0);

    reset_in_access();

    for (int k = 0; k < 40; k++) begin
      int r, waits;
      r = $urandom_range(0, 9);
      waits = (r < 8) ? (r % 4) : ((r == 8) ? TOUT : 1000);
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), waits, 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 3));
    end

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound in case a handshake never completes.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
